// File: rtl/cluster_pkg.sv
// Shared types for the cluster pass scheduler: pad/address/count widths, cluster word, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cluster_pkg;

  localparam int MXPADS = 768;
  localparam int ADR_W  = 11;
  localparam int CNT_W  = 3;
  localparam int WORD_W = CNT_W + ADR_W;

  localparam logic [ADR_W-1:0] ADR_NONE  = 11'h7FF;
  localparam logic [ADR_W-1:0] ADR_LIMIT = 11'(MXPADS);

  // Slot word layout: {cnt[2:0], adr[10:0]}
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [ADR_W-1:0] adr;
  } cluster_t;

  localparam cluster_t CLUSTER_EMPTY = '{cnt: 3'd0, adr: ADR_NONE};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cluster_slot_bank.sv
// MXPASSES-entry cluster register file with clear-to-empty and a flat output bus.
// Latency: write visible on the bus the cycle after wr_en.
// Backpressure: none; clr wins over a simultaneous write.
module cluster_slot_bank
  import cluster_pkg::*;
#(
  parameter int MXPASSES = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [2:0]                 wr_idx,
  input  logic [WORD_W-1:0]          wr_dat,
  output logic [MXPASSES*WORD_W-1:0] slots
);

  cluster_t mem_q [MXPASSES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < MXPASSES; k++) mem_q[k] <= CLUSTER_EMPTY;
    end else if (clr) begin
      for (int k = 0; k < MXPASSES; k++) mem_q[k] <= CLUSTER_EMPTY;
    end else if (wr_en) begin
      for (int k = 0; k < MXPASSES; k++)
        if (wr_idx == 3'(k)) mem_q[k] <= cluster_t'(wr_dat);
    end
  end

  for (genvar k = 0; k < MXPASSES; k++) begin : g_out
    assign slots[k*WORD_W +: WORD_W] = mem_q[k];
  end

endmodule

// File: rtl/cluster_pass_scheduler.sv
// Runs the priority encoder for up to MXPASSES passes per frame, masking each found pad (PASS_TAG_CHECK_EN adds tag check).
// Latency: ENC_LATENCY+2 clocks per pass, plus start and DONE cycles; clusters_valid pulses in DONE.
// Backpressure: none; a start while busy is dropped and flagged in sticky overrun.
module cluster_pass_scheduler
  import cluster_pkg::*;
#(
  parameter int MXPASSES    = 8,
  parameter int ENC_LATENCY = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  output logic [MXPADS-1:0]          vpf_mask,
  output logic [2:0]                 enc_pass,
  input  logic [2:0]                 enc_pass_ret,
  input  logic                       enc_found,
  input  logic [ADR_W-1:0]           enc_adr,
  input  logic [CNT_W-1:0]           enc_cnt,
  output logic [MXPASSES*WORD_W-1:0] clusters,
  output logic                       clusters_valid,
  output logic [3:0]                 n_clusters,
  output logic                       busy,
  output logic                       overrun,
  output logic                       tag_err
);

  localparam logic [3:0] WAIT_LOAD = 4'(ENC_LATENCY - 1);
  localparam logic [3:0] LAST_PASS = 4'(MXPASSES - 1);

  state_t                      state_q, state_d;
  logic [3:0]                  pass_q;
  logic [3:0]                  wait_q;
  logic [MXPADS-1:0]           mask_q;
  logic [3:0]                  n_q;
  logic [MXPASSES*WORD_W-1:0]  pub_q;
  logic [MXPASSES*WORD_W-1:0]  bank_slots;
  logic                        overrun_q;
  logic                        tag_bad;
  logic                        hit;

`ifdef PASS_TAG_CHECK_EN
  logic tag_err_q;
  assign tag_bad = (enc_pass_ret != pass_q[2:0]);
  assign tag_err = tag_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             tag_err_q <= 1'b0;
    else if (state_q == ST_CAPTURE && tag_bad) tag_err_q <= 1'b1;
  end
`else
  logic unused_pass_ret;
  assign unused_pass_ret = ^enc_pass_ret;
  assign tag_bad = 1'b0;
  assign tag_err = 1'b0;
`endif

  // Out-of-range addresses and tag mismatches end the frame like an empty encoder.
  assign hit = enc_found && (enc_adr < ADR_LIMIT) && !tag_bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (wait_q == 4'd0) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (hit && pass_q != LAST_PASS) ? ST_ISSUE : ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pass_q    <= 4'd0;
      wait_q    <= 4'd0;
      mask_q    <= '1;
      n_q       <= 4'd0;
      pub_q     <= {MXPASSES{CLUSTER_EMPTY}};
      overrun_q <= 1'b0;
    end else begin
      if (start && state_q != ST_IDLE) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_q <= '1;
            pass_q <= 4'd0;
          end
        end
        ST_ISSUE: wait_q <= WAIT_LOAD;
        ST_WAIT:  if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
        ST_CAPTURE: begin
          if (hit) begin
            mask_q[enc_adr[9:0]] <= 1'b0;
            pass_q <= pass_q + 4'd1;
          end
        end
        ST_DONE: begin
          pub_q <= bank_slots;
          n_q   <= pass_q;
        end
        default: ;
      endcase
    end
  end

  cluster_slot_bank #(.MXPASSES(MXPASSES)) u_slot_bank (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (state_q == ST_IDLE && start),
    .wr_en   (state_q == ST_CAPTURE && hit),
    .wr_idx  (pass_q[2:0]),
    .wr_dat  ({enc_cnt, enc_adr}),
    .slots   (bank_slots)
  );

  // During DONE the freshly filled bank is shown directly; afterwards the held copy.
  assign clusters_valid = (state_q == ST_DONE);
  assign clusters       = clusters_valid ? bank_slots : pub_q;
  assign n_clusters     = clusters_valid ? pass_q : n_q;
  assign busy           = (state_q != ST_IDLE);
  assign overrun        = overrun_q;
  assign enc_pass       = pass_q[2:0];
  assign vpf_mask       = mask_q;

endmodule

// File: tb/tb_cluster_pass_scheduler.sv
// Scoreboard bench for cluster_pass_scheduler with a behavioural priority-encoder model.
module tb_cluster_pass_scheduler;
  import cluster_pkg::*;

  localparam int NP  = 8;
  localparam int LAT = 3;
  localparam int CW  = NP * WORD_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [MXPADS-1:0] vpf_mask;
  logic [2:0]        enc_pass;
  logic [2:0]        enc_pass_ret;
  logic              enc_found;
  logic [10:0]       enc_adr;
  logic [2:0]        enc_cnt;
  logic [CW-1:0]     clusters;
  logic              clusters_valid;
  logic [3:0]        n_clusters;
  logic              busy;
  logic              overrun;
  logic              tag_err;

  cluster_pass_scheduler #(.MXPASSES(NP), .ENC_LATENCY(LAT)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .vpf_mask       (vpf_mask),
    .enc_pass       (enc_pass),
    .enc_pass_ret   (enc_pass_ret),
    .enc_found      (enc_found),
    .enc_adr        (enc_adr),
    .enc_cnt        (enc_cnt),
    .clusters       (clusters),
    .clusters_valid (clusters_valid),
    .n_clusters     (n_clusters),
    .busy           (busy),
    .overrun        (overrun),
    .tag_err        (tag_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Encoder model: lowest-index hit pad still enabled by the mask, delayed LAT clocks.
  bit          hit_pad [MXPADS];
  logic [2:0]  hit_cnt [MXPADS];
  int          bad_tag_pass = -1;
  logic        p_found [LAT];
  logic [10:0] p_adr   [LAT];
  logic [2:0]  p_cnt   [LAT];
  logic [2:0]  p_tag   [LAT];

  always @(posedge clock) begin : enc_model
    logic        f;
    logic [10:0] a;
    logic [2:0]  c;
    f = 1'b0; a = 11'h7FF; c = 3'd0;
    for (int i = 0; i < MXPADS; i++)
      if (!f && hit_pad[i] && vpf_mask[i]) begin
        f = 1'b1; a = 11'(i); c = hit_cnt[i];
      end
    for (int s = LAT - 1; s > 0; s--) begin
      p_found[s] <= p_found[s-1];
      p_adr[s]   <= p_adr[s-1];
      p_cnt[s]   <= p_cnt[s-1];
      p_tag[s]   <= p_tag[s-1];
    end
    p_found[0] <= f;
    p_adr[0]   <= a;
    p_cnt[0]   <= c;
    p_tag[0]   <= (int'(enc_pass) == bad_tag_pass) ? 3'd2 : enc_pass;
  end

  assign enc_found    = p_found[LAT-1];
  assign enc_adr      = p_adr[LAT-1];
  assign enc_cnt      = p_cnt[LAT-1];
  assign enc_pass_ret = p_tag[LAT-1];

  typedef struct {
    logic [CW-1:0] cl;
    logic [3:0]    n;
  } exp_t;

  exp_t          sb[$];
  int            n_valid = 0;
  logic [CW-1:0] empty_cl;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && clusters_valid) begin
      n_valid++;
      if (sb.size() == 0) chk("spurious_valid", 768'(1), 768'(0));
      else begin
        e = sb.pop_front();
        chk("clusters", 768'(clusters), 768'(e.cl));
        chk("n_clusters", 768'(n_clusters), 768'(e.n));
      end
    end
  end

  task automatic clear_hits();
    for (int i = 0; i < MXPADS; i++) begin
      hit_pad[i] = 1'b0;
      hit_cnt[i] = 3'd0;
    end
  endtask

  task automatic add_hit(input int pad, input int cnt);
    hit_pad[pad] = 1'b1;
    hit_cnt[pad] = 3'(cnt);
  endtask

  task automatic push_exp(input int limit);
    exp_t e;
    int   n;
    e.cl = empty_cl;
    n = 0;
    for (int i = 0; i < MXPADS; i++)
      if (hit_pad[i] && n < limit) begin
        e.cl[n*WORD_W +: WORD_W] = {hit_cnt[i], 11'(i)};
        n++;
      end
    e.n = 4'(n);
    sb.push_back(e);
  endtask

  // cycles = clocks from the start cycle (1) through the clusters_valid cycle.
  task automatic run_frame(input int restart_at, output int cycles);
    int c;
    @(negedge clock);
    start = 1'b1;
    c = 1;
    do begin
      @(negedge clock);
      c++;
      start = (c == restart_at) ? 1'b1 : 1'b0;
    end while (!clusters_valid && c < 200);
    start = 1'b0;
    if (c >= 200) chk("frame_timeout", 768'(0), 768'(1));
    cycles = c;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int cyc;
    int pads10 [10];
    logic [7:0] found_bits;
    pads10 = '{3, 40, 41, 100, 200, 350, 500, 600, 700, 766};
    for (int k = 0; k < NP; k++) empty_cl[k*WORD_W +: WORD_W] = {3'd0, 11'h7FF};
    clear_hits();

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_busy", 768'(busy), 768'(0));
    chk("rst_valid", 768'(clusters_valid), 768'(0));
    chk("rst_n_clusters", 768'(n_clusters), 768'(0));
    chk("rst_overrun", 768'(overrun), 768'(0));
    chk("rst_tag_err", 768'(tag_err), 768'(0));
    chk("rst_enc_pass", 768'(enc_pass), 768'(0));
    chk("rst_mask", 768'(vpf_mask), {768{1'b1}});
    chk("rst_clusters", 768'(clusters), 768'(empty_cl));

    // three hits
    clear_hits();
    add_hit(5, 1); add_hit(300, 2); add_hit(767, 7);
    push_exp(NP);
    run_frame(0, cyc);
    chk("three_latency", 768'(cyc), 768'(22));
    chk("three_pulses", 768'(n_valid), 768'(1));
    chk("three_hold_n", 768'(n_clusters), 768'(3));
    chk("three_busy", 768'(busy), 768'(0));

    // ten hits: only the lowest eight are reported
    clear_hits();
    for (int i = 0; i < 10; i++) add_hit(pads10[i], (i + 1) % 8);
    push_exp(NP);
    run_frame(0, cyc);
    chk("ten_latency", 768'(cyc), 768'(42));
    chk("ten_pulses", 768'(n_valid), 768'(2));
    for (int i = 0; i < 8; i++) found_bits[i] = vpf_mask[pads10[i]];
    chk("ten_mask_found", 768'(found_bits), 768'(0));
    chk("ten_mask_left", 768'({vpf_mask[pads10[8]], vpf_mask[pads10[9]]}), 768'(2'b11));

    // no hits
    clear_hits();
    push_exp(NP);
    run_frame(0, cyc);
    chk("nohit_latency", 768'(cyc), 768'(7));
    chk("nohit_pulses", 768'(n_valid), 768'(3));
    chk("nohit_clusters", 768'(clusters), 768'(empty_cl));
    chk("pre_overrun", 768'(overrun), 768'(0));

    // second start during the WAIT of the 4th pass
    clear_hits();
    add_hit(5, 1); add_hit(300, 2); add_hit(767, 7);
    push_exp(NP);
    run_frame(19, cyc);
    chk("ovr_latency", 768'(cyc), 768'(22));
    chk("ovr_flag", 768'(overrun), 768'(1));
    chk("ovr_pulses", 768'(n_valid), 768'(4));

`ifdef PASS_TAG_CHECK_EN
    clear_hits();
    add_hit(10, 3); add_hit(20, 4); add_hit(30, 5);
    bad_tag_pass = 1;
    push_exp(1);
    run_frame(0, cyc);
    bad_tag_pass = -1;
    chk("tag_err_set", 768'(tag_err), 768'(1));
    chk("tag_n", 768'(n_clusters), 768'(1));
`else
    chk("tag_err_tied", 768'(tag_err), 768'(0));
`endif

    // reset in WAIT of pass index 2; no pulse may follow
    clear_hits();
    for (int i = 0; i < 10; i++) add_hit(pads10[i], 6);
    cyc = n_valid;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    chk("pre_rst_busy", 768'(busy), 768'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 768'(busy), 768'(0));
    chk("arst_valid", 768'(clusters_valid), 768'(0));
    chk("arst_n_clusters", 768'(n_clusters), 768'(0));
    chk("arst_overrun", 768'(overrun), 768'(0));
    chk("arst_tag_err", 768'(tag_err), 768'(0));
    chk("arst_enc_pass", 768'(enc_pass), 768'(0));
    chk("arst_mask", 768'(vpf_mask), {768{1'b1}});
    chk("arst_clusters", 768'(clusters), 768'(empty_cl));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    chk("arst_no_pulse", 768'(n_valid), 768'(cyc));
    chk("sb_drained", 768'(sb.size()), 768'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cluster_pass_scheduler.md
# cluster_pass_scheduler

Sequences the 768-pad priority encoder through up to MXPASSES passes per frame, so that one frame yields several clusters instead of one. For each pass the block issues a pass tag, waits out the encoder latency and captures the returned address/count. It then masks the found pad so the next pass finds the next cluster, and finally publishes the assembled cluster list. It sits between the cluster-finding front end (its mask gates the encoder's vpfs input) and the cluster packer/serializer.

## Interface
- MXPASSES, 8: maximum clusters per frame (1..8).
- MXPADS, 768: pads covered by the encoder.
- ENC_LATENCY, 3: clocks from a registered vpfs/pass change to the matching adr/cnt/pass_out at the encoder output.
- clock  in  1  160 MHz fabric clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame strobe; begins a new sequence.
- vpf_mask  out  MXPADS  per-pad enable, ANDed with encoder vpfs_in upstream; 1 = pad eligible.
- enc_pass  out  3  pass tag driven to encoder pass_in.
- enc_pass_ret  in  3  encoder pass_out.
- enc_found  in  1  encoder cluster_found.
- enc_adr  in  11  encoder adr (all-ones when nothing found).
- enc_cnt  in  3  encoder cnt.
- clusters  out  MXPASSES*14  slot k = {cnt[2:0], adr[10:0]} at bits [14k+13:14k].
- clusters_valid  out  1  one-cycle strobe; clusters holds a complete frame.
- n_clusters  out  4  number of valid slots, 0..MXPASSES.
- busy  out  1  sequence in progress.
- overrun  out  1  sticky; start arrived while busy.
- tag_err  out  1  sticky; returned pass tag mismatch (see Configuration).

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE: on start, set vpf_mask to all-ones, set pass index p=0, clear the slot registers to all-ones adr with cnt 0, assert busy, go to ISSUE.
- ISSUE (1 cycle): drive enc_pass=p, load wait counter with ENC_LATENCY-1, go to WAIT.
- WAIT: decrement the counter; at 0 go to CAPTURE.
- CAPTURE (1 cycle): sample enc_found/enc_adr/enc_cnt.
  - If enc_found: write slot p = {enc_cnt, enc_adr}, clear vpf_mask[enc_adr], p<=p+1. If p+1==MXPASSES go to DONE, else go to ISSUE.
  - If not enc_found: go to DONE; remaining slots stay empty.
- DONE (1 cycle): pulse clusters_valid, set n_clusters=p, deassert busy, return to IDLE.
- A start received in any state other than IDLE is ignored and sets overrun.
- An enc_adr >= MXPADS while found is treated as not found.
- The sticky flags clear only on reset.
- The clusters and n_clusters outputs hold their values until the next DONE.

## Timing
- Reset values:
  - state IDLE; busy 0; clusters_valid 0; n_clusters 0; overrun 0; tag_err 0; enc_pass 0.
  - vpf_mask all-ones.
  - clusters: every slot adr 0x7FF, cnt 0.
- Pass period is ENC_LATENCY+2 clocks (ISSUE + ENC_LATENCY WAIT + CAPTURE), i.e. 5 clocks at the default.
- Mask update from CAPTURE is registered, so it is visible to the encoder on the cycle ISSUE begins.
- Worst-case sequence length: 1 + MXPASSES*(ENC_LATENCY+2) + 1 = 42 clocks at the defaults.
- clusters_valid rises 1 clock after the final CAPTURE.
- Reset mid-sequence aborts immediately to the reset values and produces no clusters_valid.

## Configuration
- PASS_TAG_CHECK_EN defined:
  - In CAPTURE, compare enc_pass_ret with p; on mismatch set tag_err and treat the result as not found.
- PASS_TAG_CHECK_EN undefined:
  - enc_pass_ret is ignored and tag_err is tied to 0.

## Structure
- Shared package cluster_pkg holds:
  - MXPADS, the 11-bit address width, the 3-bit count width and the 14-bit cluster word layout.
  - The state enumeration.
  - The invalid-address constant 0x7FF.
- One sub-module, cluster_slot_bank: MXPASSES-entry register file with write enable and index, reset/clear to the empty word, flat output bus.

## Test plan
- Three hits at pads 5, 300 and 767 with cnts 1, 2, 7:
  - Required: slots = {1,5}, {2,300}, {7,767}, rest empty; n_clusters=3; clusters_valid once.
- Ten hits:
  - Required: exactly 8 slots filled, in ascending address order; n_clusters=8; pads of the 9th and 10th hits remain unmasked.
- No hits (enc_found=0):
  - Required: clusters_valid 7 clocks after start (ENC_LATENCY=3); n_clusters=0; all slots adr 0x7FF.
- start pulsed again during the 4th pass:
  - Required: overrun=1; the sequence completes unchanged.
- With PASS_TAG_CHECK_EN, a model returns pass tag 2 during pass 1:
  - Required: tag_err=1; n_clusters=1.
- reset_n low during WAIT of pass 2:
  - Required: all outputs return to reset values asynchronously; no clusters_valid pulse is produced.
